// File: rtl/mod_n_step_counter_pkg.sv
// Shared definitions for the modulo-N stepping counter and its prescaler.
package step_pkg;

    // Direction encoding for the up input.
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // End-of-range behaviour selected by the SATURATE parameter.
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/mod_n_step_counter_prescale_tick.sv
// Prescaler: counts enabled cycles and emits a tick on the last one of
// every group of PRESCALE enabled cycles.
module prescale_tick
    import step_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = clog2_min1(PRESCALE);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("prescale_tick: PRESCALE must be >= 1");
    end

    logic [PW-1:0] pre;

    // Prescale phase register: restarts on clr, advances only while enabled.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst) begin
            pre <= '0;
        end else if (clr) begin
            pre <= '0;
        end else if (en) begin
            pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
        end
    end

    assign tick = en & (pre == PRE_MAX);

endmodule

// File: rtl/mod_n_step_counter.sv
// Modulo-MODULUS up/down counter advancing once per PRESCALE enabled
// cycles, with wrap or saturate at the range ends, synchronous clear/load,
// terminal-count flag and a registered wrap pulse.
module mod_n_step_counter
    import step_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int MODULUS  = 4,
    parameter int PRESCALE = 1,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("mod_n_step_counter: MODULUS must be in 2..2**WIDTH");
    end

    logic             tick;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap;

    // Clear and load both restart the prescale phase.
    prescale_tick #(
        .PRESCALE(PRESCALE)
    ) u_prescale (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (clear | load),
        .tick(tick)
    );

    // A tick only becomes a step when neither clear nor load overrides it.
    assign step = tick & ~clear & ~load;

    assign tc = (up == DIR_UP) ? (count == MAX_COUNT) : (count == '0);

    // Next count and wrap flag, priority clear > load > step.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        next_count = count;
        next_wrap  = 1'b0;
        if (clear) begin
            next_count = '0;
        end else if (load) begin
            next_count = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
        end else if (step) begin
            if (up == DIR_UP) begin
                if (count != MAX_COUNT) begin
                    next_count = count + 1'b1;
                end else if (SATURATE != MODE_SAT) begin
                    next_count = '0;
                    next_wrap  = 1'b1;
                end
            end else begin
                if (count != '0) begin
                    next_count = count - 1'b1;
                end else if (SATURATE != MODE_SAT) begin
                    next_count = MAX_COUNT;
                    next_wrap  = 1'b1;
                end
            end
        end
    end

    // Count and wrap-pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= next_count;
            wrap  <= next_wrap;
        end
    end

endmodule

// File: tb/tb_mod_n_step_counter.sv
// Directed bench for mod_n_step_counter: three instances with different
// parameter sets share one clock and reset, driven from one vector table
// plus hand-written asynchronous-reset sequences.
module tb_mod_n_step_counter;

    logic clk;
    logic rst;

    // Instance A: defaults (WIDTH=2, MODULUS=4, PRESCALE=1, wrap).
    logic       en_a, up_a, clear_a, load_a, step_a, tc_a, wrap_a;
    logic [1:0] load_val_a, count_a;
    // Instance B: WIDTH=3, MODULUS=5, PRESCALE=3, wrap.
    logic       en_b, up_b, clear_b, load_b, step_b, tc_b, wrap_b;
    logic [2:0] load_val_b, count_b;
    // Instance C: WIDTH=3, MODULUS=6, PRESCALE=1, saturate.
    logic       en_c, up_c, clear_c, load_c, step_c, tc_c, wrap_c;
    logic [2:0] load_val_c, count_c;

    mod_n_step_counter dut_a (
        .clk(clk), .rst(rst), .en(en_a), .up(up_a), .clear(clear_a),
        .load(load_a), .load_val(load_val_a), .count(count_a),
        .step(step_a), .tc(tc_a), .wrap(wrap_a)
    );

    mod_n_step_counter #(.WIDTH(3), .MODULUS(5), .PRESCALE(3), .SATURATE(0)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .up(up_b), .clear(clear_b),
        .load(load_b), .load_val(load_val_b), .count(count_b),
        .step(step_b), .tc(tc_b), .wrap(wrap_b)
    );

    mod_n_step_counter #(.WIDTH(3), .MODULUS(6), .PRESCALE(1), .SATURATE(1)) dut_c (
        .clk(clk), .rst(rst), .en(en_c), .up(up_c), .clear(clear_c),
        .load(load_c), .load_val(load_val_c), .count(count_c),
        .step(step_c), .tc(tc_c), .wrap(wrap_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic       en;
        logic       up;
        logic       clear;
        logic       load;
        logic [2:0] load_val;
        logic [2:0] exp_count;
        logic       exp_step;
        logic       chk_step;
        logic       exp_tc;
        logic       exp_wrap;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp;
    int   n_fail;

    function automatic vec_t mk(int id, logic en, logic up, logic clr, logic ld,
                                logic [2:0] lv, logic [2:0] c, logic s,
                                logic t, logic w, logic cs = 1'b1);
        vec_t v;
        v.id = id; v.en = en; v.up = up; v.clear = clr; v.load = ld;
        v.load_val = lv; v.exp_count = c; v.exp_step = s; v.chk_step = cs;
        v.exp_tc = t; v.exp_wrap = w;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        case (v.id)
            0: begin en_a = v.en; up_a = v.up; clear_a = v.clear; load_a = v.load;
                      load_val_a = v.load_val[1:0]; end
            1: begin en_b = v.en; up_b = v.up; clear_b = v.clear; load_b = v.load;
                      load_val_b = v.load_val; end
            default: begin en_c = v.en; up_c = v.up; clear_c = v.clear; load_c = v.load;
                      load_val_c = v.load_val; end
        endcase
    endtask

    task automatic sample(input int id, output logic [2:0] c, output logic s,
                          output logic t, output logic w);
        case (id)
            0:       begin c = {1'b0, count_a}; s = step_a; t = tc_a; w = wrap_a; end
            1:       begin c = count_b; s = step_b; t = tc_b; w = wrap_b; end
            default: begin c = count_c; s = step_c; t = tc_c; w = wrap_c; end
        endcase
    endtask

    initial begin
        logic [2:0] c;
        logic       s, t, w;
        n_cmp  = 0;
        n_fail = 0;

        // Instance A: wrap up 0..3, then down across 0 -> 3.
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 2, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 3, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 2, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 3, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 1));
        // Instance C: saturate at 5, reverse, saturate at 0.
        tbl.push_back(mk(2, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(2, 1, 1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(2, 1, 1, 0, 0, 0, 2, 1, 0, 0));
        tbl.push_back(mk(2, 1, 1, 0, 0, 0, 3, 1, 0, 0));
        tbl.push_back(mk(2, 1, 1, 0, 0, 0, 4, 1, 0, 0));
        tbl.push_back(mk(2, 1, 1, 0, 0, 0, 5, 1, 1, 0));
        tbl.push_back(mk(2, 1, 1, 0, 0, 0, 5, 1, 1, 0));
        tbl.push_back(mk(2, 1, 1, 0, 0, 0, 5, 1, 1, 0));
        tbl.push_back(mk(2, 1, 0, 0, 0, 0, 5, 1, 0, 0));
        tbl.push_back(mk(2, 1, 0, 0, 0, 0, 4, 1, 0, 0));
        tbl.push_back(mk(2, 1, 0, 0, 0, 0, 3, 1, 0, 0));
        tbl.push_back(mk(2, 1, 0, 0, 0, 0, 2, 1, 0, 0));
        tbl.push_back(mk(2, 1, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(2, 1, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(2, 1, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // Instance C: clamped load, then clear beating load.
        tbl.push_back(mk(2, 0, 1, 0, 1, 7, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 0, 1, 0, 0, 0, 5, 0, 1, 0));
        tbl.push_back(mk(2, 1, 1, 1, 1, 3, 5, 0, 1, 0, 0));
        tbl.push_back(mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // Instance B: down every 3 cycles, en gap, load with step pending.
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 4, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 4, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 4, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 3, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 3, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 3, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 2, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 2, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 3, 0, 0, 0));

        // Reset with all inputs idle.
        rst = 1'b0;
        en_a = 0; up_a = 0; clear_a = 0; load_a = 0; load_val_a = '0;
        en_b = 0; up_b = 0; clear_b = 0; load_b = 0; load_val_b = '0;
        en_c = 0; up_c = 0; clear_c = 0; load_c = 0; load_val_c = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset count_a", 32'(count_a), 0);
        check("reset wrap_a", 32'(wrap_a), 0);
        check("reset count_b", 32'(count_b), 0);
        check("reset count_c", 32'(count_c), 0);
        rst = 1'b1;

        // Each row: drive inputs, let them settle, check the cycle's
        // outputs, then cross one rising edge.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            #1;
            sample(tbl[i].id, c, s, t, w);
            check($sformatf("row%0d count", i), 32'(c), 32'(tbl[i].exp_count));
            check($sformatf("row%0d tc", i), 32'(t), 32'(tbl[i].exp_tc));
            check($sformatf("row%0d wrap", i), 32'(w), 32'(tbl[i].exp_wrap));
            if (tbl[i].chk_step)
                check($sformatf("row%0d step", i), 32'(s), 32'(tbl[i].exp_step));
            @(posedge clk);
            #1;
        end

        // Instance B now sits at count=3, pre=1. Assert reset between edges.
        en_b = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async rst count_b", 32'(count_b), 0);
        check("async rst wrap_b", 32'(wrap_b), 0);
        check("async rst count_a", 32'(count_a), 0);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        en_b = 1'b1;
        up_b = 1'b1;
        // Partial prescale must be gone: step only on the third cycle.
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("post-rst cyc%0d step_b", k), 32'(step_b), (k == 2) ? 1 : 0);
            check($sformatf("post-rst cyc%0d count_b", k), 32'(count_b), 0);
            @(posedge clk);
            #1;
        end
        check("post-rst first step count_b", 32'(count_b), 1);
        check("post-rst wrap_b", 32'(wrap_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
